pep_mmacc_gram_req_sched: RTL and testbench

// Requester-side scheduler placed in front of the GRAM arbiter, one instance per requester (mmfeed or mmacc).
// It queues GRAM access commands and issues them to the arbiter on a valid/ready handshake.

---
 rtl/pep_mmacc_gram_req_sched.sv | 170 +++++++++++++++++
 tb/tb_pep_mmacc_gram_req_sched.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pep_mmacc_gram_req_sched.sv
// Requester-side GRAM scheduler: queues access commands, issues them to the arbiter,
// enforces re-request holdoff and generates the slot-aligned one-hot access window.
module pep_mmacc_gram_req_sched #(
    parameter  int GRAM_NB    = 4,
    parameter  int SLOT_CYCLE = 8,
    parameter  int SLOT_NB    = 4,
    parameter  int FIFO_DEPTH = 4,
    localparam int GRAM_ID_W  = $clog2(GRAM_NB),
    localparam int SLOT_W     = $clog2(SLOT_NB)
) (
    input  logic                 clk,
    input  logic                 a_rst,
    input  logic [GRAM_ID_W-1:0] in_grid,
    input  logic                 in_critical,
    input  logic                 in_vld,
    output logic                 in_rdy,
    output logic [GRAM_ID_W-1:0] garb_req_grid,
    output logic                 garb_req_critical,
    output logic                 garb_req_vld,
    input  logic                 garb_req_rdy,
    input  logic                 garb_grant,
    output logic [GRAM_NB-1:0]   win_avail_1h,
    output logic [SLOT_W-1:0]    win_slot,
    output logic                 win_last,
    output logic                 busy,
    output logic                 err_grant,
    output logic                 err_overlap
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CYC_W  = $clog2(SLOT_CYCLE);
    localparam int HOLD_W = $clog2((SLOT_NB - 1) * SLOT_CYCLE + 1);

    localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'((SLOT_NB - 1) * SLOT_CYCLE);
    localparam logic [CYC_W-1:0]  CYC_LOAD  = CYC_W'(SLOT_CYCLE - 1);
    localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_NB - 1);
    localparam logic [PTR_W:0]    FIFO_FULL = (PTR_W + 1)'(FIFO_DEPTH);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    logic [GRAM_ID_W:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W:0]       fifo_cnt;
    logic                 fifo_empty;
    logic                 fifo_full;
    logic                 push;
    logic                 pop;
    logic [GRAM_ID_W:0]   head;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [HOLD_W-1:0]    holdoff_cnt;
    logic                 hold_ok;
    logic                 grant_ok;
    logic [GRAM_ID_W-1:0] pend_grid;

    logic                 win_open;
    logic [GRAM_ID_W-1:0] win_grid;
    logic [SLOT_W-1:0]    slot_cnt;
    logic [CYC_W-1:0]     cyc_cnt;

    // Command queue; a full queue still takes a push in the cycle the head is popped.
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FIFO_FULL);
    assign pop        = garb_req_vld & garb_req_rdy;
    assign in_rdy     = ~fifo_full | pop;
    assign push       = in_vld & in_rdy;
    assign head       = fifo_mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {in_grid, in_critical};
        end
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Entering REQ one cycle early lets garb_req_vld rise exactly when holdoff reaches 0.
    assign hold_ok  = (holdoff_cnt <= HOLD_W'(1));
    assign grant_ok = garb_grant & (state == ST_WAIT);

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if ((~fifo_empty | push) & hold_ok) state_nxt = ST_REQ;
            ST_REQ:  if (garb_req_rdy) state_nxt = ST_WAIT;
            ST_WAIT: if (garb_grant) state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            state       <= ST_IDLE;
            holdoff_cnt <= '0;
            pend_grid   <= '0;
        end else begin
            state <= state_nxt;
            if (grant_ok) begin
                holdoff_cnt <= HOLD_LOAD;
            end else if (holdoff_cnt != '0) begin
                holdoff_cnt <= holdoff_cnt - 1'b1;
            end
            if (pop) begin
                pend_grid <= head[GRAM_ID_W:1];
            end
        end
    end

    assign garb_req_vld      = (state == ST_REQ);
    assign garb_req_grid     = garb_req_vld ? head[GRAM_ID_W:1] : '0;
    assign garb_req_critical = garb_req_vld & head[0];

    // Window: slot index counts up, cycle-in-slot counts down to its terminal 0.
    always_ff @(posedge clk or posedge a_rst) begin
        if (a_rst) begin
            win_open <= 1'b0;
            win_grid <= '0;
            slot_cnt <= '0;
            cyc_cnt  <= '0;
        end else if (grant_ok) begin
            win_open <= 1'b1;
            win_grid <= pend_grid;
            slot_cnt <= '0;
            cyc_cnt  <= CYC_LOAD;
        end else if (win_open) begin
            if (cyc_cnt == '0) begin
                if (slot_cnt == SLOT_LAST) begin
                    win_open <= 1'b0;
                    slot_cnt <= '0;
                end else begin
                    slot_cnt <= slot_cnt + 1'b1;
                    cyc_cnt  <= CYC_LOAD;
                end
            end else begin
                cyc_cnt <= cyc_cnt - 1'b1;
            end
        end
    end

    assign win_avail_1h = win_open ? (GRAM_NB'(1) << win_grid) : '0;
    assign win_slot     = slot_cnt;
    assign win_last     = win_open & (slot_cnt == SLOT_LAST) & (cyc_cnt == '0);

    assign busy        = ~fifo_empty | (state != ST_IDLE) | win_open;
    assign err_grant   = garb_grant & (state != ST_WAIT) & ~a_rst;
    assign err_overlap = garb_grant & win_open & ~a_rst;

endmodule

// File: tb/tb_pep_mmacc_gram_req_sched.sv
// Bench for pep_mmacc_gram_req_sched: directed scenarios plus random traffic, every
// cycle checked against a timestamp-based behavioural model of the scheduler.
module tb_pep_mmacc_gram_req_sched;

    localparam int SLOT_CYCLE = 8;
    localparam int SLOT_NB    = 4;
    localparam int WIN_LEN    = SLOT_NB * SLOT_CYCLE;
    localparam int HOLD       = (SLOT_NB - 1) * SLOT_CYCLE;

    logic       clk = 1'b0;
    logic       a_rst = 1'b1;
    logic [1:0] in_grid = '0;
    logic       in_critical = 1'b0;
    logic       in_vld = 1'b0;
    logic       in_rdy;
    logic [1:0] garb_req_grid;
    logic       garb_req_critical;
    logic       garb_req_vld;
    logic       garb_req_rdy = 1'b0;
    logic       garb_grant = 1'b0;
    logic [3:0] win_avail_1h;
    logic [1:0] win_slot;
    logic       win_last;
    logic       busy;
    logic       err_grant;
    logic       err_overlap;

    always #5 clk = ~clk;

    pep_mmacc_gram_req_sched #(
        .GRAM_NB(4), .SLOT_CYCLE(SLOT_CYCLE), .SLOT_NB(SLOT_NB), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .a_rst(a_rst),
        .in_grid(in_grid), .in_critical(in_critical), .in_vld(in_vld), .in_rdy(in_rdy),
        .garb_req_grid(garb_req_grid), .garb_req_critical(garb_req_critical),
        .garb_req_vld(garb_req_vld), .garb_req_rdy(garb_req_rdy), .garb_grant(garb_grant),
        .win_avail_1h(win_avail_1h), .win_slot(win_slot), .win_last(win_last),
        .busy(busy), .err_grant(err_grant), .err_overlap(err_overlap)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Model: queue contents, issue phase (0 idle, 1 requesting, 2 awaiting grant) and timestamps.
    logic [2:0] mq[$];
    int         m_phase;
    int         m_cyc = 0;
    int         m_last_grant;
    int         m_win_start;
    logic [1:0] m_pend;
    logic [1:0] m_win_grid;

    logic [3:0] s_win;
    logic [1:0] s_slot, s_grid;
    logic       s_last, s_req_vld, s_in_rdy, s_busy, s_eg, s_eo;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, m_cyc);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_phase      = 0;
        m_last_grant = -1000;
        m_win_start  = -1000;
        m_pend       = '0;
        m_win_grid   = '0;
    endtask

    task automatic check_cycle();
        int         off;
        bit         open, e_req, pop, push, e_in_rdy;
        logic [1:0] e_grid;
        logic       e_crit;
        off      = m_cyc - m_win_start;
        open     = (off >= 0) && (off < WIN_LEN);
        e_req    = (m_phase == 1);
        e_grid   = e_req ? mq[0][2:1] : 2'd0;
        e_crit   = e_req ? mq[0][0] : 1'b0;
        pop      = e_req && garb_req_rdy;
        e_in_rdy = (mq.size() < 4) || pop;
        push     = in_vld && e_in_rdy;
        chk("in_rdy", 32'(in_rdy), 32'(e_in_rdy));
        chk("req_vld", 32'(garb_req_vld), 32'(e_req));
        chk("req_grid", 32'(garb_req_grid), 32'(e_grid));
        chk("req_critical", 32'(garb_req_critical), 32'(e_crit));
        chk("win_avail_1h", 32'(win_avail_1h), open ? (32'd1 << m_win_grid) : 32'd0);
        chk("win_slot", 32'(win_slot), open ? 32'(off / SLOT_CYCLE) : 32'd0);
        chk("win_last", 32'(win_last), 32'(open && off == WIN_LEN - 1));
        chk("busy", 32'(busy), 32'(mq.size() > 0 || m_phase != 0 || open));
        chk("err_grant", 32'(err_grant), 32'(garb_grant && m_phase != 2));
        chk("err_overlap", 32'(err_overlap), 32'(garb_grant && open));
        s_win = win_avail_1h; s_slot = win_slot; s_last = win_last; s_req_vld = garb_req_vld;
        s_grid = garb_req_grid; s_in_rdy = in_rdy; s_busy = busy; s_eg = err_grant; s_eo = err_overlap;
        case (m_phase)
            0: begin
                if (push) mq.push_back({in_grid, in_critical});
                if (mq.size() > 0 && m_cyc + 1 >= m_last_grant + HOLD + 1) m_phase = 1;
            end
            1: begin
                if (pop) begin
                    m_pend = mq[0][2:1];
                    void'(mq.pop_front());
                    m_phase = 2;
                end
                if (push) mq.push_back({in_grid, in_critical});
            end
            default: begin
                if (push) mq.push_back({in_grid, in_critical});
                if (garb_grant) begin
                    m_phase      = 0;
                    m_last_grant = m_cyc;
                    m_win_start  = m_cyc + 1;
                    m_win_grid   = m_pend;
                end
            end
        endcase
        m_cyc++;
    endtask

    task automatic step(input logic vld, input logic [1:0] grid, input logic crit,
                        input logic rdy, input logic grant);
        @(negedge clk);
        in_vld = vld; in_grid = grid; in_critical = crit; garb_req_rdy = rdy; garb_grant = grant;
        #1;
        check_cycle();
    endtask

    task automatic do_reset();
        @(negedge clk);
        a_rst = 1'b1; in_vld = 1'b0; garb_req_rdy = 1'b0; garb_grant = 1'b0;
        #1;
        model_reset();
        chk("rst_win", 32'(win_avail_1h), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_rdy", 32'(in_rdy), 32'd1);
        chk("rst_req_vld", 32'(garb_req_vld), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_edge_win", 32'(win_avail_1h), 32'd0);
        @(negedge clk);
        @(negedge clk);
        a_rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt, last_off, acc_step, grants, rises;
        int slot_at[4];
        int grant_cyc[3];
        int rise_cyc[3];
        logic [1:0] acc_grid[3];
        bit grant_next, prev_vld, seen;

        model_reset();
        do_reset();

        // Single command grid=2, grant 5 cycles after accept.
        step(1, 2'd2, 1'b0, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 2'd0, 1'b0, 1'b1, 1'b0);
            seen = s_req_vld;
        end
        chk("s1_accept_seen", 32'(seen), 32'd1);
        repeat (4) step(0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("s1_grant_no_err", 32'(s_eg), 32'd0);
        cnt = 0; last_off = -1;
        for (int i = 0; i < 40; i++) begin
            step(0, 2'd0, 1'b0, 1'b0, 1'b0);
            if (s_win == 4'b0100) begin
                if (cnt % SLOT_CYCLE == 0) slot_at[cnt / SLOT_CYCLE] = int'(s_slot);
                if (s_last) last_off = cnt;
                cnt++;
            end
        end
        chk("s1_win_len", 32'(cnt), 32'd32);
        for (int k = 0; k < 4; k++) chk("s1_slot_step", 32'(slot_at[k]), 32'(k));
        chk("s1_last_off", 32'(last_off), 32'd31);

        // Three back-to-back commands, grant one cycle after each accept.
        do_reset();
        acc_grid = '{default: 2'd0};
        grant_next = 0; prev_vld = 0; grants = 0; rises = 0;
        for (int i = 0; i < 120; i++) begin
            logic [1:0] g;
            g = (i == 0) ? 2'd1 : (i == 1) ? 2'd3 : 2'd0;
            step(i < 3, g, 1'b1, 1'b1, grant_next);
            if (grant_next && grants < 3) begin grant_cyc[grants] = m_cyc - 1; grants++; end
            if (s_req_vld && !prev_vld && rises < 3) begin
                rise_cyc[rises] = m_cyc - 1;
                acc_grid[rises] = s_grid;
                rises++;
            end
            prev_vld = s_req_vld;
            grant_next = s_req_vld;
        end
        chk("s2_grants", 32'(grants), 32'd3);
        chk("s2_rise_gap1", 32'(rise_cyc[1] - grant_cyc[0]), 32'd25);
        chk("s2_rise_gap2", 32'(rise_cyc[2] - grant_cyc[1]), 32'd25);
        chk("s2_grid0", 32'(acc_grid[0]), 32'd1);
        chk("s2_grid1", 32'(acc_grid[1]), 32'd3);
        chk("s2_grid2", 32'(acc_grid[2]), 32'd0);

        // Fill the queue while the arbiter stalls.
        do_reset();
        for (int i = 0; i < 4; i++) step(1, 2'(i), 1'b0, 1'b0, 1'b0);
        step(0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("s3_full_rdy", 32'(s_in_rdy), 32'd0);
        step(1, 2'd2, 1'b1, 1'b1, 1'b0);
        chk("s3_pushpop_rdy", 32'(s_in_rdy), 32'd1);
        step(0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("s3_still_full", 32'(s_in_rdy), 32'd0);

        // Spurious grant in IDLE.
        do_reset();
        step(0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("s4_err_grant", 32'(s_eg), 32'd1);
        step(1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("s4_err_grant_pulse", 32'(s_eg), 32'd0);
        chk("s4_no_window", 32'(s_win), 32'd0);
        step(0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("s4_no_holdoff", 32'(s_req_vld), 32'd1);

        // Overlapping grant replaces the open window.
        do_reset();
        grant_next = 0; grants = 0; seen = 0;
        for (int i = 0; i < 80 && grants < 2; i++) begin
            step(i < 2, (i == 0) ? 2'd1 : 2'd2, 1'b0, 1'b1, grant_next);
            if (grant_next) grants++;
            grant_next = s_req_vld;
        end
        chk("s5_grants", 32'(grants), 32'd2);
        chk("s5_err_overlap", 32'(s_eo), 32'd1);
        step(0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("s5_new_onehot", 32'(s_win), 32'b0100);
        cnt = 1;
        for (int i = 0; i < 40; i++) begin
            step(0, 2'd0, 1'b0, 1'b0, 1'b0);
            if (s_win == 4'b0100) cnt++;
        end
        chk("s5_win_len", 32'(cnt), 32'd32);

        // Reset at window offset 12 with two entries queued.
        do_reset();
        grant_next = 0; cnt = 0;
        for (int i = 0; i < 60 && cnt < 12; i++) begin
            step(i < 3, 2'(i + 1), 1'b0, 1'b1, grant_next);
            grant_next = s_req_vld;
            if (s_win != 4'd0) cnt++;
        end
        chk("s6_offset", 32'(cnt), 32'd12);
        do_reset();
        step(1, 2'd3, 1'b1, 1'b1, 1'b0);
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(0, 2'd0, 1'b0, 1'b1, 1'b0);
            seen = s_req_vld;
        end
        chk("s6_reissue", 32'(seen), 32'd1);
        chk("s6_reissue_grid", 32'(s_grid), 32'd3);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic gr;
            gr = (m_phase == 2) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 59) == 0);
            step(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), gr);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
